// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared PWM widths and on/off types plus the capture FSM states
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif
`ifndef DIVCLK_WIDTH
`define DIVCLK_WIDTH 5
`endif

package pwm_capture_pkg;
   typedef enum logic {PWM_OFF, PWM_ON} _pwm_onoff;
   typedef enum logic {INT_OFF, INT_ON} _int_onoff;
   typedef enum logic {CLKDIV_OFF, CLKDIV_ON} _clkdiv_onoff;
   typedef enum logic [1:0] {CAP_IDLE, CAP_ARM, CAP_HIGH, CAP_LOW} _cap_state;
endpackage

// File: rtl/pwm_capture_edge_filter.sv
// pwm_edge_filter: synchronizer, glitch filter and registered rise/fall detection
module pwm_edge_filter
   import pwm_capture_pkg::*;
#(
   parameter int FILT_WIDTH = `DTCOUNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  pwm_in,
   input  logic [FILT_WIDTH-1:0] filt_len,
   output logic                  rise_evt,
   output logic                  fall_evt
);
   logic [1:0]            sync;
   logic                  filt;
   logic                  filt_d;
   logic [FILT_WIDTH-1:0] dcnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync     <= '0;
         filt     <= 1'b0;
         filt_d   <= 1'b0;
         dcnt     <= '0;
         rise_evt <= 1'b0;
         fall_evt <= 1'b0;
      end else begin
         sync     <= {sync[0], pwm_in};
         filt_d   <= filt;
         rise_evt <= filt & ~filt_d;
         fall_evt <= ~filt & filt_d;
         // filt follows only after filt_len+1 consecutive differing samples
         if (sync[1] == filt)
            dcnt <= '0;
         else if (dcnt == filt_len) begin
            filt <= sync[1];
            dcnt <= '0;
         end else
            dcnt <= dcnt + 1'b1;
      end
   end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and on-time of a filtered PWM gate in prescaled ticks
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_WIDTH  = `PWMCOUNT_WIDTH,
   parameter int FILT_WIDTH = `DTCOUNT_WIDTH,
   parameter int DIV_WIDTH  = `DIVCLK_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic                  pwm_in,
   input  logic [FILT_WIDTH-1:0] filt_len,
   input  logic                  clkdiv_en,
   input  logic [DIV_WIDTH-1:0]  clkdiv,
   input  logic                  int_en,
   output logic [CNT_WIDTH-1:0]  period,
   output logic [CNT_WIDTH-1:0]  on_time,
   output logic                  meas_valid,
   output logic                  overflow,
   output logic                  irq
);
   _cap_state            state, state_d;
   logic                 rise_evt, fall_evt;
   logic                 tick, timeout, publish, capture, ovf_set;
   logic [DIV_WIDTH-1:0] pcnt;
   logic [CNT_WIDTH-1:0] cnt, nxt, sat, on_cap;

   pwm_edge_filter #(.FILT_WIDTH(FILT_WIDTH)) u_filter (
      .clk      (clk),
      .rstn     (rstn),
      .pwm_in   (pwm_in),
      .filt_len (filt_len),
      .rise_evt (rise_evt),
      .fall_evt (fall_evt)
   );

   assign tick    = (clkdiv_en == CLKDIV_OFF) || (pcnt == clkdiv);
   assign nxt     = cnt + CNT_WIDTH'(tick);
   // a rise coinciding with the wrap reports a saturated period
   assign sat     = (&cnt && tick) ? '1 : nxt;
   assign timeout = (state == CAP_HIGH || state == CAP_LOW) && (&cnt) && tick;

   always_comb begin
      state_d = state;
      publish = 1'b0;
      capture = 1'b0;
      ovf_set = 1'b0;
      if (en == PWM_OFF)
         state_d = CAP_IDLE;
      else
         case (state)
            CAP_IDLE: state_d = CAP_ARM;
            CAP_ARM:  state_d = rise_evt ? CAP_HIGH : CAP_ARM;
            CAP_HIGH:
               if (timeout) begin
                  ovf_set = 1'b1;
                  state_d = CAP_ARM;
               end else if (fall_evt) begin
                  capture = 1'b1;
                  state_d = CAP_LOW;
               end
            CAP_LOW:
               if (rise_evt) begin
                  publish = 1'b1;
                  state_d = CAP_HIGH;
               end else if (timeout) begin
                  ovf_set = 1'b1;
                  state_d = CAP_ARM;
               end
            default:  state_d = CAP_IDLE;
         endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= CAP_IDLE;
         pcnt       <= '0;
         cnt        <= '0;
         on_cap     <= '0;
         period     <= '0;
         on_time    <= '0;
         meas_valid <= 1'b0;
         overflow   <= 1'b0;
         irq        <= 1'b0;
      end else begin
         state      <= state_d;
         pcnt       <= (state == CAP_IDLE || rise_evt || tick) ? '0 : pcnt + 1'b1;
         cnt        <= (state == CAP_IDLE || rise_evt) ? '0 : nxt;
         on_cap     <= capture ? nxt : on_cap;
         period     <= publish ? sat : period;
         on_time    <= publish ? on_cap : on_time;
         meas_valid <= publish;
         overflow   <= (en == PWM_OFF || publish) ? 1'b0 : (overflow | ovf_set);
         irq        <= (int_en == INT_ON) && (publish || (ovf_set && !overflow));
      end
   end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed checks of pwm_capture against an arithmetic model
module tb_pwm_capture;
   logic        clk = 1'b0;
   logic        rstn, en, pwm_in, clkdiv_en, int_en;
   logic [7:0]  filt_len;
   logic [4:0]  clkdiv;
   logic [15:0] period, on_time;
   logic        meas_valid, overflow, irq;
   int compared = 0, mismatched = 0;
   int mv_cnt = 0, irq_cnt = 0, irq_mv_cnt = 0;
   int q_per[$], q_on[$];

   always #5 clk = ~clk;

   pwm_capture dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .pwm_in     (pwm_in),
      .filt_len   (filt_len),
      .clkdiv_en  (clkdiv_en),
      .clkdiv     (clkdiv),
      .int_en     (int_en),
      .period     (period),
      .on_time    (on_time),
      .meas_valid (meas_valid),
      .overflow   (overflow),
      .irq        (irq)
   );

   always @(negedge clk) begin
      if (meas_valid) begin
         q_per.push_back(int'(period));
         q_on.push_back(int'(on_time));
         mv_cnt++;
      end
      if (irq) begin
         irq_cnt++;
         if (meas_valid) irq_mv_cnt++;
      end
   end

   // reference: ticks counted in an interval of n cycles that starts on a prescaler restart
   function automatic int ticks(input int n, input bit cde, input int cd);
      return cde ? n / (cd + 1) : n;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_wave(input int h, input int l, input int n);
      repeat (n) begin
         pwm_in = 1'b1;
         cyc(h);
         pwm_in = 1'b0;
         cyc(l);
      end
   endtask

   task automatic setup(input int fl, input bit cde, input int cd, input bit ie);
      en = 1'b0;
      pwm_in = 1'b0;
      cyc(12);
      filt_len = 8'(fl);
      clkdiv_en = cde;
      clkdiv = 5'(cd);
      int_en = ie;
      cyc(fl + 8);
      en = 1'b1;
      cyc(2);
   endtask

   task automatic test_reset;
      rstn = 1'b0; en = 1'b0; pwm_in = 1'b0; filt_len = '0;
      clkdiv_en = 1'b0; clkdiv = '0; int_en = 1'b0;
      cyc(3);
      compared++;
      if (period !== 16'd0) begin mismatched++; $display("FAIL reset_period: got %0d want 0", period); end
      compared++;
      if (on_time !== 16'd0) begin mismatched++; $display("FAIL reset_on_time: got %0d want 0", on_time); end
      compared++;
      if ({meas_valid, overflow, irq} !== 3'b000)
         begin mismatched++; $display("FAIL reset_flags: got %b want 000", {meas_valid, overflow, irq}); end
      rstn = 1'b1;
      cyc(2);
   endtask

   task automatic test_basic;
      int b, m0, i0, j0;
      setup(0, 1'b0, 0, 1'b0);
      b = q_per.size(); i0 = irq_cnt;
      drive_wave(3, 5, 10);
      cyc(10);
      compared++;
      if (q_per.size() - b !== 9) begin mismatched++; $display("FAIL basic_count: got %0d want 9", q_per.size() - b); end
      for (int i = b; i < q_per.size(); i++) begin
         compared++;
         if (q_per[i] !== ticks(8, 0, 0) || q_on[i] !== ticks(3, 0, 0))
            begin mismatched++; $display("FAIL basic_result[%0d]: got %0d/%0d want 8/3", i - b, q_per[i], q_on[i]); end
      end
      compared++;
      if (irq_cnt !== i0) begin mismatched++; $display("FAIL basic_irq_off: got %0d pulses want 0", irq_cnt - i0); end
      int_en = 1'b1;
      m0 = mv_cnt; i0 = irq_cnt; j0 = irq_mv_cnt;
      drive_wave(3, 5, 4);
      cyc(10);
      compared++;
      if (mv_cnt - m0 !== 4) begin mismatched++; $display("FAIL basic_valid_on: got %0d want 4", mv_cnt - m0); end
      compared++;
      if (irq_cnt - i0 !== 4 || irq_mv_cnt - j0 !== 4)
         begin mismatched++; $display("FAIL basic_irq_on: got %0d (%0d with valid) want 4", irq_cnt - i0, irq_mv_cnt - j0); end
   endtask

   task automatic test_latency;
      int fl;
      fl = $urandom_range(0, 5);
      setup(fl, 1'b0, 0, 1'b0);
      drive_wave(10, 10, 2);
      pwm_in = 1'b1;
      cyc(4 + fl);
      compared++;
      if (meas_valid !== 1'b0) begin mismatched++; $display("FAIL latency_early fl=%0d: got %b want 0", fl, meas_valid); end
      cyc(1);
      compared++;
      if (meas_valid !== 1'b1 || period !== 16'd20)
         begin mismatched++; $display("FAIL latency_edge fl=%0d: got valid=%b period=%0d want 1/20", fl, meas_valid, period); end
      cyc(5);
      pwm_in = 1'b0;
      cyc(10);
   endtask

   task automatic test_glitch;
      int b;
      setup(2, 1'b0, 0, 1'b0);
      b = q_per.size();
      repeat (4) begin
         pwm_in = 1'b1; cyc(8); pwm_in = 1'b0; cyc(2);
         pwm_in = 1'b1; cyc(10); pwm_in = 1'b0; cyc(20);
      end
      cyc(10);
      compared++;
      if (q_per.size() - b !== 3) begin mismatched++; $display("FAIL glitch2_count: got %0d want 3", q_per.size() - b); end
      for (int i = b; i < q_per.size(); i++) begin
         compared++;
         if (q_per[i] !== 40 || q_on[i] !== 20)
            begin mismatched++; $display("FAIL glitch2_result[%0d]: got %0d/%0d want 40/20", i - b, q_per[i], q_on[i]); end
      end
      setup(2, 1'b0, 0, 1'b0);
      b = q_per.size();
      repeat (4) begin
         pwm_in = 1'b1; cyc(8); pwm_in = 1'b0; cyc(3);
         pwm_in = 1'b1; cyc(9); pwm_in = 1'b0; cyc(20);
      end
      cyc(10);
      compared++;
      if (q_per.size() - b !== 7) begin mismatched++; $display("FAIL glitch3_count: got %0d want 7", q_per.size() - b); end
      for (int i = b; i < q_per.size(); i++) begin
         compared++;
         if ((i - b) % 2 == 0 ? (q_per[i] !== 11 || q_on[i] !== 8) : (q_per[i] !== 29 || q_on[i] !== 9))
            begin mismatched++; $display("FAIL glitch3_result[%0d]: got %0d/%0d", i - b, q_per[i], q_on[i]); end
      end
   endtask

   task automatic test_prescale;
      int b;
      setup(0, 1'b1, 3, 1'b0);
      b = q_per.size();
      drive_wave(40, 60, 4);
      cyc(10);
      compared++;
      if (q_per.size() - b !== 3) begin mismatched++; $display("FAIL prescale_count: got %0d want 3", q_per.size() - b); end
      for (int i = b; i < q_per.size(); i++) begin
         compared++;
         if (q_per[i] !== ticks(100, 1, 3) || q_on[i] !== ticks(40, 1, 3))
            begin mismatched++; $display("FAIL prescale_result[%0d]: got %0d/%0d want 25/10", i - b, q_per[i], q_on[i]); end
      end
   endtask

   task automatic test_overflow;
      int b, m0, i0;
      setup(0, 1'b0, 0, 1'b1);
      m0 = mv_cnt; i0 = irq_cnt;
      pwm_in = 1'b1;
      cyc(70000);
      compared++;
      if (overflow !== 1'b1) begin mismatched++; $display("FAIL overflow_set: got %b want 1", overflow); end
      compared++;
      if (mv_cnt !== m0 || irq_cnt - i0 !== 1)
         begin mismatched++; $display("FAIL overflow_events: got valid=%0d irq=%0d want 0/1", mv_cnt - m0, irq_cnt - i0); end
      compared++;
      if (period !== 16'd25 || on_time !== 16'd10)
         begin mismatched++; $display("FAIL overflow_hold: got %0d/%0d want 25/10", period, on_time); end
      pwm_in = 1'b0;
      cyc(5);
      b = q_per.size();
      drive_wave(3, 5, 3);
      cyc(10);
      compared++;
      if (q_per.size() - b !== 2) begin mismatched++; $display("FAIL overflow_recover_count: got %0d want 2", q_per.size() - b); end
      for (int i = b; i < q_per.size(); i++) begin
         compared++;
         if (q_per[i] !== 8 || q_on[i] !== 3)
            begin mismatched++; $display("FAIL overflow_recover[%0d]: got %0d/%0d want 8/3", i - b, q_per[i], q_on[i]); end
      end
      compared++;
      if (overflow !== 1'b0) begin mismatched++; $display("FAIL overflow_clear: got %b want 0", overflow); end
   endtask

   task automatic test_enable;
      int b;
      setup(0, 1'b0, 0, 1'b0);
      drive_wave(3, 5, 4);
      pwm_in = 1'b1;
      cyc(2);
      en = 1'b0;
      cyc(2);
      compared++;
      if (overflow !== 1'b0 || period !== 16'd8 || on_time !== 16'd3)
         begin mismatched++; $display("FAIL enable_off: got ovf=%b %0d/%0d want 0 8/3", overflow, period, on_time); end
      pwm_in = 1'b0;
      cyc(5);
      en = 1'b1;
      cyc(2);
      b = q_per.size();
      drive_wave(4, 6, 3);
      cyc(10);
      compared++;
      if (q_per.size() - b !== 2) begin mismatched++; $display("FAIL enable_rearm_count: got %0d want 2", q_per.size() - b); end
      for (int i = b; i < q_per.size(); i++) begin
         compared++;
         if (q_per[i] !== 10 || q_on[i] !== 4)
            begin mismatched++; $display("FAIL enable_rearm[%0d]: got %0d/%0d want 10/4", i - b, q_per[i], q_on[i]); end
      end
   endtask

   task automatic test_reset_mid;
      int b;
      setup(0, 1'b0, 0, 1'b0);
      drive_wave(3, 5, 3);
      pwm_in = 1'b1; cyc(3); pwm_in = 1'b0; cyc(2);
      rstn = 1'b0;
      cyc(1);
      compared++;
      if (period !== 16'd0 || on_time !== 16'd0 || {meas_valid, overflow, irq} !== 3'b000)
         begin mismatched++; $display("FAIL reset_mid: got %0d/%0d flags=%b want 0/0 000", period, on_time, {meas_valid, overflow, irq}); end
      rstn = 1'b1;
      cyc(5);
      b = q_per.size();
      drive_wave(6, 4, 3);
      cyc(10);
      compared++;
      if (q_per.size() - b !== 2) begin mismatched++; $display("FAIL reset_mid_count: got %0d want 2", q_per.size() - b); end
      for (int i = b; i < q_per.size(); i++) begin
         compared++;
         if (q_per[i] !== 10 || q_on[i] !== 6)
            begin mismatched++; $display("FAIL reset_mid_result[%0d]: got %0d/%0d want 10/6", i - b, q_per[i], q_on[i]); end
      end
   endtask

   task automatic test_random;
      int b, fl, cd, h, l;
      bit cde;
      repeat (6) begin
         fl  = $urandom_range(0, 3);
         cde = 1'($urandom_range(0, 1));
         cd  = $urandom_range(0, 4);
         h   = $urandom_range(fl + 2, 30);
         l   = $urandom_range(fl + 2, 30);
         setup(fl, cde, cd, 1'b0);
         b = q_per.size();
         drive_wave(h, l, 4);
         cyc(fl + 10);
         compared++;
         if (q_per.size() - b !== 3) begin mismatched++; $display("FAIL random_count h=%0d l=%0d: got %0d want 3", h, l, q_per.size() - b); end
         for (int i = b; i < q_per.size(); i++) begin
            compared++;
            if (q_per[i] !== ticks(h + l, cde, cd) || q_on[i] !== ticks(h, cde, cd))
               begin mismatched++; $display("FAIL random_result h=%0d l=%0d fl=%0d div=%0b/%0d: got %0d/%0d want %0d/%0d",
                  h, l, fl, cde, cd, q_per[i], q_on[i], ticks(h + l, cde, cd), ticks(h, cde, cd)); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_latency;
      test_glitch;
      test_prescale;
      test_overflow;
      test_enable;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM capture unit: the measuring end of the carrier/PWM generator path. It samples an external or fed-back gate signal, filters glitches, and measures period and on-time in prescaled clock ticks, publishing one result per carrier cycle with a valid strobe and optional interrupt. It sits beside the PWM generators in the PL and reports to the AXI register file for closed-loop checks of duty cycle and frequency.

## Interface
- CNT_WIDTH, `PWMCOUNT_WIDTH (16): width of the tick counter and of the result registers
- FILT_WIDTH, `DTCOUNT_WIDTH (8): width of the glitch-filter length
- DIV_WIDTH, `DIVCLK_WIDTH (5): width of the prescaler value
- clk  in  1  system clock
- rstn  in  1  synchronous, active-low reset
- en  in  1  _pwm_onoff; PWM_OFF forces CAP_IDLE
- pwm_in  in  1  asynchronous PWM input
- filt_len  in  FILT_WIDTH  glitch-filter length; the filter requires filt_len+1 stable cycles
- clkdiv_en  in  1  _clkdiv_onoff
- clkdiv  in  DIV_WIDTH  prescaler; one tick every clkdiv+1 cycles
- int_en  in  1  _int_onoff
- period  out  CNT_WIDTH  last measured period, in ticks
- on_time  out  CNT_WIDTH  last measured high time, in ticks
- meas_valid  out  1  one-cycle strobe when period and on_time update
- overflow  out  1  sticky timeout flag
- irq  out  1  one-cycle interrupt pulse

## Operation
- **Input path**
  - pwm_in passes through a 2-FF synchronizer.
  - The glitch filter drives filt. filt takes the synchronized value after that value has differed from filt for filt_len+1 consecutive clk cycles.
  - The differ counter clears whenever the synchronized value equals filt.
  - rise_evt = filt rising; fall_evt = filt falling. Both are single-cycle, derived from filt and a registered copy of filt.
- **Tick generation**
  - clkdiv_en=CLKDIV_OFF: tick=1 every cycle.
  - clkdiv_en=CLKDIV_ON: a prescaler counts 0..clkdiv and tick=1 when it equals clkdiv.
  - The prescaler clears in CAP_IDLE and on rise_evt.
- **Counter**
  - cnt holds the number of ticks since the last rise_evt.
  - nxt = cnt + tick.
  - On rise_evt, cnt <= 0; otherwise cnt <= nxt.
- **FSM** (_cap_state)
  - CAP_IDLE: en=PWM_ON -> CAP_ARM.
  - CAP_ARM: rise_evt -> CAP_HIGH and cnt cleared. fall_evt is ignored. No result is produced, because the first partial cycle is discarded.
  - CAP_HIGH: fall_evt -> on_cap <= nxt, then CAP_LOW.
  - CAP_LOW: rise_evt -> period <= nxt, on_time <= on_cap, meas_valid=1, overflow cleared, cnt cleared, stay in CAP_HIGH path (next state CAP_HIGH).
- **Timeout**
  - Applies in CAP_HIGH or CAP_LOW when cnt is all-ones and tick=1.
  - Sets overflow and returns to CAP_ARM.
  - period and on_time hold their previous values; no meas_valid.
  - A constant input at 0 % or 100 % duty therefore produces overflow.
- **Interrupt**
  - irq = int_en & (meas_valid | the cycle overflow is set, going 0->1).
- **Enable deassert**
  - en=PWM_OFF in any state -> CAP_IDLE on the next edge. overflow clears; period and on_time hold.
- **Simultaneous events**
  - Timeout and rise_evt in the same cycle: rise_evt wins and a valid result is published with period = all-ones.

## Timing
- Reset (rstn=0 at an edge): period=0, on_time=0, meas_valid=0, overflow=0, irq=0, state CAP_IDLE, filt=0, all counters 0.
- A reset asserted mid-measurement discards the measurement.
- Latency: pwm_in rise sampled at edge k -> meas_valid high after edge k+4+filt_len.
- Both edges see equal delay, so the measurement is unaffected by latency.
- irq is coincident with meas_valid.
- Inputs filt_len, clkdiv and clkdiv_en are assumed quasi-static. A change mid-cycle corrupts only the current measurement.

## Structure
- Add to the shared PWM package:
  - _cap_state enum logic [1:0] {CAP_IDLE, CAP_ARM, CAP_HIGH, CAP_LOW}.
- Reuse from the shared PWM package:
  - _pwm_onoff, _int_onoff and _clkdiv_onoff.
  - The width macros as parameter defaults.
- Sub-module pwm_edge_filter contains the synchronizer, glitch filter and rise/fall detection. pwm_capture holds the prescaler, counter, FSM and outputs.

## Test plan
- filt_len=0, clkdiv off, square wave high 3 / low 5 cycles -> from the second rise on, period=8, on_time=3, meas_valid once per 8 cycles; irq pulses only with int_en=1.
- filt_len=2, high 20 / low 20 with a 2-cycle low glitch inside the high phase -> glitch rejected, period=40, on_time=20. With a 3-cycle glitch the filter passes it and short measurements appear.
- clkdiv_en on, clkdiv=3, high 40 / low 60 -> period=25, on_time=10.
- CNT_WIDTH=16, pwm_in held high for 70000 cycles after the first rise -> overflow=1 and an irq pulse with int_en=1, no meas_valid; a subsequent clean wave clears overflow on its first valid result.
- Reset and enable:
  - rstn pulled low in CAP_LOW -> all outputs 0, and the next result requires a fresh arming rise.
  - en low mid-cycle -> CAP_IDLE, overflow=0, period held.
